// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for serial_sub.
// The zero/neg/ovf flag signals exist only when SERSUB_FLAGS_EN is defined.
interface serial_sub_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dif;
    logic             bout;
`ifdef SERSUB_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output start, A, B, bin,
        input  busy, done, dif, bout, zero, neg, ovf
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, dif, bout, zero, neg, ovf
    );
`else
    modport master (
        output start, A, B, bin,
        input  busy, done, dif, bout
    );

    modport slave (
        input  start, A, B, bin,
        output busy, done, dif, bout
    );
`endif
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes A-B-bin one bit per clock, LSB first, in WIDTH cycles.
// Define SERSUB_FLAGS_EN to add zero/neg/ovf result flags.
module serial_sub #(
    parameter int WIDTH = 10,
    parameter int CW    = 5
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] opA_q,     opA_d;
    logic [WIDTH-1:0] opB_q,     opB_d;
    logic             aMsb_q,    aMsb_d;
    logic             bMsb_q,    bMsb_d;
    logic             borrow_q,  borrow_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [WIDTH-1:0] dif_q,     dif_d;
    logic             bout_q,    bout_d;
`ifdef SERSUB_FLAGS_EN
    logic             zero_q,    zero_d;
    logic             neg_q,     neg_d;
    logic             ovf_q,     ovf_d;
`endif

    logic             diffBit;
    logic             borrowNext;
    logic             lastBit;
    logic [WIDTH-1:0] shiftedDif;

    // Operands shift right so the active bit is always at index 0; result bits enter at the MSB.
    always_comb begin
        diffBit    = opA_q[0] ^ opB_q[0] ^ borrow_q;
        borrowNext = (~opA_q[0] & opB_q[0]) | (~(opA_q[0] ^ opB_q[0]) & borrow_q);
        lastBit    = (count_q == CW'(WIDTH - 1));
        shiftedDif = {diffBit, dif_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        aMsb_d   = aMsb_q;
        bMsb_d   = bMsb_q;
        borrow_d = borrow_q;
        count_d  = count_q;
        dif_d    = dif_q;
        bout_d   = bout_q;
`ifdef SERSUB_FLAGS_EN
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opA_d    = bus.A;
                    opB_d    = bus.B;
                    aMsb_d   = bus.A[WIDTH-1];
                    bMsb_d   = bus.B[WIDTH-1];
                    borrow_d = bus.bin;
                    count_d  = '0;
                    dif_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                opA_d    = opA_q >> 1;
                opB_d    = opB_q >> 1;
                borrow_d = borrowNext;
                dif_d    = shiftedDif;
                if (lastBit) begin
                    bout_d  = borrowNext;
                    state_d = DONE;
`ifdef SERSUB_FLAGS_EN
                    // Flags come from the completed difference, so they are valid together with done.
                    zero_d  = (shiftedDif == '0);
                    neg_d   = diffBit;
                    ovf_d   = (aMsb_q ^ bMsb_q) & (aMsb_q ^ diffBit);
`endif
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            dif_q    <= '0;
            bout_q   <= 1'b0;
`ifdef SERSUB_FLAGS_EN
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
            borrow_q <= borrow_d;
            count_q  <= count_d;
            dif_q    <= dif_d;
            bout_q   <= bout_d;
`ifdef SERSUB_FLAGS_EN
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.dif  = dif_q;
    assign bus.bout = bout_q;
`ifdef SERSUB_FLAGS_EN
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, operand and difference width in bits; legal range 2..32.
REQ-002 The module SHALL have parameter CW, default 5, bit-counter width; must satisfy 2**CW >= WIDTH.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The module SHALL have port start  input  1  request to begin one subtraction; sampled on clk.
REQ-006 The module SHALL have port A  input  WIDTH  minuend.
REQ-007 The module SHALL have port B  input  WIDTH  subtrahend.
REQ-008 The module SHALL have port bin  input  1  borrow-in.
REQ-009 The module SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-010 The module SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 The module SHALL have port dif  output  WIDTH  difference A-B-bin, modulo 2**WIDTH.
REQ-012 The module SHALL have port bout  output  1  borrow-out of the MSB.
REQ-013 The module SHALL have flag ports zero, neg and ovf, each output 1, present only when SERSUB_FLAGS_EN is defined (REQ-031).

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL latch A, B and bin into internal registers, clear the bit counter and the dif register, and enter RUN.
REQ-016 In RUN, each edge SHALL process bit i=counter LSB-first: dif[i]=A[i]^B[i]^br, br_next=(~A[i]&B[i])|(~(A[i]^B[i])&br), with br initialised to the latched bin.
REQ-017 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge the FSM SHALL enter DONE and bout SHALL take the final br.
REQ-018 Latency SHALL be fixed: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing; A/B/bin changes during RUN SHALL have no effect.
REQ-022 dif and bout SHALL hold the last result from DONE until the next accepted start; dif bits SHALL be undefined-to-user (but deterministic) during RUN.
REQ-023 Counter SHALL NOT wrap: it terminates at WIDTH-1 regardless of CW.
REQ-024 A start back-to-back after DONE SHALL be accepted in the IDLE cycle immediately following, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, dif=0, bout=0, counter=0, and all flags=0.
REQ-026 rst SHALL take priority over start and SHALL abort a RUN in progress with no done pulse.
REQ-027 The first start SHALL be accepted at the first edge where rst=0.

Configuration
REQ-028 Macro SERSUB_FLAGS_EN SHALL select flag generation.
REQ-029 When defined, zero SHALL be 1 iff dif==0, neg SHALL be dif[WIDTH-1], and ovf SHALL be (A[MSB]^B[MSB]) & (A[MSB]^dif[MSB]) using the latched operands; all three SHALL update in DONE.
REQ-030 Flags SHALL hold their values with dif until the next accepted start.
REQ-031 When undefined, the zero, neg and ovf ports and their logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-032 WIDTH=10, A=5, B=3, bin=0, start pulse -> done exactly 10 cycles after the start edge, dif=2, bout=0, busy high for 10 cycles.
REQ-033 A=0, B=1, bin=0 -> dif=0x3FF, bout=1; A=0, B=0, bin=1 -> dif=0x3FF, bout=1; with flags, neg=1.
REQ-034 With flags: A=0x200, B=1 -> dif=0x1FF, ovf=1, neg=0; A=7, B=7 -> dif=0, zero=1, bout=0.
REQ-035 start re-asserted and A changed on cycle 3 of RUN -> no restart and result from the originally latched operands; rst asserted on cycle 5 of RUN -> no done, all outputs 0 next cycle.
REQ-036 WIDTH=4, CW=2: exhaustive A, B, bin (512 cases) -> dif and bout equal the reference A-B-bin modulo 16, with done after 4 cycles each.
